// File: rtl/if_prefetch_if.sv
// ---------------------------------------------------------------------------
// if_prefetch_if : fetch-request, fetch-response and decode-side handshakes
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface if_prefetch_if;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    input  mem_req_ready,
    input  mem_rsp_valid,
    input  mem_rsp_data,
    output out_valid,
    output out_pc,
    output out_inst,
    input  out_ready
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_req_ready,
    output mem_rsp_valid,
    output mem_rsp_data,
    input  out_valid,
    input  out_pc,
    input  out_inst,
    output out_ready
  );
endinterface

`default_nettype wire

// File: rtl/if_prefetch.sv
// ---------------------------------------------------------------------------
// if_prefetch : in-order instruction prefetch queue with redirect and
//               stale-response dropping
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module if_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RST_ADDR = 32'h0000_0000,
  parameter logic [31:0] INT_ADDR = 32'h0000_0010
) (
  input  wire           clk,
  input  wire           rst_flag,
  input  wire           int_flag,
  input  wire           redir_valid,
  input  wire [31:0]    redir_addr,
  if_prefetch_if.master bus
);

  localparam int unsigned PW        = $clog2(DEPTH);
  localparam int unsigned CW        = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_CMP = DEPTH[CW:0];

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   head_pc_q,  head_pc_d;
  logic [CW-1:0] cnt_q,      cnt_d;
  logic [CW-1:0] outst_q,    outst_d;
  logic [CW-1:0] drop_q,     drop_d;
  logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [31:0]   queue_q [DEPTH];
  logic [31:0]   queue_d [DEPTH];

  logic          redirect;
  logic [31:0]   target;
  logic [CW:0]   occupancy;
  logic          req_ok;
  logic          req_fire;
  logic          rsp_fire;
  logic          deq_fire;
  logic          enq;

  // Interrupt (active-low) outranks a branch redirect.
  assign redirect  = ~int_flag | redir_valid;
  assign target    = ~int_flag ? {INT_ADDR[31:2], 2'b00} : {redir_addr[31:2], 2'b00};

  // In-flight fetches (stale ones included) reserve a queue slot, so the
  // queue can never overflow.
  assign occupancy = {1'b0, cnt_q} + {1'b0, outst_q};
  assign req_ok    = rst_flag & ~redirect & (occupancy < DEPTH_CMP);
  assign req_fire  = req_ok & bus.mem_req_ready;
  assign rsp_fire  = bus.mem_rsp_valid;
  assign deq_fire  = (cnt_q != '0) & bus.out_ready;
  assign enq       = rsp_fire & (drop_q == '0);

  assign bus.mem_req_valid = req_ok;
  assign bus.mem_req_addr  = fetch_pc_q;
  assign bus.out_valid     = (cnt_q != '0);
  assign bus.out_pc        = head_pc_q;
  assign bus.out_inst      = queue_q[rd_ptr_q];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_pc_d  = head_pc_q;
    cnt_d      = cnt_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    queue_d    = queue_q;

    case ({req_fire, rsp_fire})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase

    if (rsp_fire && (drop_q != '0)) begin
      drop_d = drop_q - CW'(1);
    end

    if (enq) begin
      queue_d[wr_ptr_q] = bus.mem_rsp_data;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    if (deq_fire) begin
      rd_ptr_d  = rd_ptr_q + PW'(1);
      head_pc_d = head_pc_q + 32'd4;
    end

    case ({enq, deq_fire})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    // Every fetch still in flight after this edge becomes stale; stale
    // fetches are already part of outst, so drop tracks outst exactly.
    if (redirect) begin
      fetch_pc_d = target;
      head_pc_d  = target;
      cnt_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      drop_d     = outst_q - CW'(rsp_fire);
    end
  end

  always_ff @(posedge clk or negedge rst_flag) begin
    if (!rst_flag) begin
      fetch_pc_q <= RST_ADDR;
      head_pc_q  <= RST_ADDR;
      cnt_q      <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      queue_q    <= '{default: '0};
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_pc_q  <= head_pc_d;
      cnt_q      <= cnt_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      queue_q    <= queue_d;
    end
  end

endmodule

`default_nettype wire
